// File: rtl/yourcpu_pkg.sv
// Shared types for the data-memory readback engine.
// State encoding and word-size helpers.
package yourcpu_pkg;

  typedef enum logic [2:0] {
    RB_IDLE,
    RB_REQ,
    RB_CAP,
    RB_SEND,
    RB_FIN
  } rb_state_e;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 16;
  localparam int WORD_BYTES = DEF_DATA_W / 8;

  function automatic int word_bytes(
    input int data_w
  );
    return data_w / 8;
  endfunction

endpackage

// File: rtl/yourcpu_dmem_readback_if.sv
// Memory read port and bench stream channel
// of the data-memory readback engine.
interface yourcpu_dmem_readback_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic [DATA_W-1:0] mem_rdata;

  logic              tb_valid;
  logic              tb_ready;
  logic [ADDR_W-1:0] tb_addr;
  logic [DATA_W-1:0] tb_data;
  logic              tb_last;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_gnt,
    input  mem_rdata,
    output tb_valid,
    input  tb_ready,
    output tb_addr,
    output tb_data,
    output tb_last
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_gnt,
    output mem_rdata,
    input  tb_valid,
    output tb_ready,
    input  tb_addr,
    input  tb_data,
    input  tb_last
  );

endinterface

// File: rtl/yourcpu_dmem_readback.sv
// Walks a block of data memory through the shared read port
// and streams (address, word) pairs out with a running checksum.
module yourcpu_dmem_readback
  import yourcpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  yourcpu_dmem_readback_if.master bus
);

  localparam int STRIDE = word_bytes(DATA_W);
  localparam logic [ADDR_W-1:0] STRIDE_A =
    ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] ALIGN =
    ~(STRIDE_A - ADDR_W'(1));
  localparam logic [CNT_W-1:0] ONE =
    CNT_W'(1);

  rb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [ADDR_W-1:0] tb_addr_q, tb_addr_d;
  logic [DATA_W-1:0] tb_data_q, tb_data_d;
  logic              tb_last_q, tb_last_d;
  logic              tb_valid_q, tb_valid_d;
  logic              mem_req_q, mem_req_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              hs;

  assign hs = tb_valid_q && bus.tb_ready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    sum_d     = sum_q;
    tb_addr_d = tb_addr_q;
    tb_data_d = tb_data_q;
    unique case (state_q)
      RB_IDLE: begin
        if (start) begin
          addr_d  = base_addr & ALIGN;
          rem_d   = word_count;
          sum_d   = '0;
          state_d = (word_count == '0) ?
                    RB_FIN : RB_REQ;
        end
      end
      RB_REQ: begin
        if (bus.mem_gnt) state_d = RB_CAP;
      end
      RB_CAP: begin
        tb_addr_d = addr_q;
        tb_data_d = bus.mem_rdata;
        state_d   = RB_SEND;
      end
      RB_SEND: begin
        if (hs) begin
          sum_d = sum_q + tb_data_q;
          if (rem_q == ONE) begin
            state_d = RB_FIN;
          end else begin
            state_d = RB_REQ;
            addr_d  = addr_q + STRIDE_A;
            rem_d   = rem_q - ONE;
          end
        end
      end
      RB_FIN: state_d = RB_IDLE;
      default: state_d = RB_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they come straight off flops.
  always_comb begin
    mem_req_d  = (state_d == RB_REQ);
    tb_valid_d = (state_d == RB_SEND);
    tb_last_d  = (state_d == RB_SEND) &&
                 (rem_d == ONE);
    done_d     = (state_d == RB_FIN);
    busy_d     = (state_d == RB_REQ)  ||
                 (state_d == RB_CAP)  ||
                 (state_d == RB_SEND);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RB_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      sum_q      <= '0;
      tb_addr_q  <= '0;
      tb_data_q  <= '0;
      tb_last_q  <= 1'b0;
      tb_valid_q <= 1'b0;
      mem_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      sum_q      <= sum_d;
      tb_addr_q  <= tb_addr_d;
      tb_data_q  <= tb_data_d;
      tb_last_q  <= tb_last_d;
      tb_valid_q <= tb_valid_d;
      mem_req_q  <= mem_req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign checksum     = sum_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = addr_q;
  assign bus.tb_valid = tb_valid_q;
  assign bus.tb_addr  = tb_addr_q;
  assign bus.tb_data  = tb_data_q;
  assign bus.tb_last  = tb_last_q;

endmodule
